rv64_encoder: RTL and testbench
===============================

Name: rv64_encoder

Overview:
- Inverse of the instruction decoder: takes decoded fields (format, opcode, funct3/funct7, register indices, immediate or target address) and packs them into a 32-bit RV64IM instruction word.
- Feeds the test-program generator and the self-check path that re-decodes the emitted words.
- Structure: two register stages (offset/range check, then bit packing) followed by an output FIFO with valid/ready handshakes on both sides.

Parameters:
DEPTH, 4, output FIFO entries (minimum 2)
XLEN, 64, width of in_imm and in_pc

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready at rising edge
in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SH(shift-imm) 7=reserved
in_opc  input  7  major opcode, insn[6:0]
in_funct3  input  3  insn[14:12]
in_funct7  input  7  insn[31:25] for R; for SH, upper shift bits
in_rd  input  5  destination register
in_rs1  input  5  source 1
in_rs2  input  5  source 2
in_imm  input  XLEN  I/S: signed imm; U: 20-bit field value; B/J: absolute target address; SH: shamt
in_pc  input  XLEN  address of the instruction being encoded
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_insn  output  32  encoded word
out_illegal  output  1  request could not be encoded
out_pc  output  XLEN  in_pc carried with the word

Behaviour:
- Reset, asynchronous: FIFO empty and both stage valids cleared.
  - Reset values: out_valid=0, out_insn=0, out_illegal=0, out_pc=0, in_ready=0 while reset is high.
  - Entries in flight at reset are discarded.
- Stage 1, on accept: registers the fields.
  - B/J: off = in_imm - in_pc (XLEN-bit two's complement).
  - Other formats: off = in_imm.
- Stage 2: range check and packing; the result is written to the FIFO on the next edge.
  - Latency: accepted at edge N, out_valid high after edge N+2 if the FIFO was empty.
- Stages never stall. in_ready = (fifo_count + s1_valid + s2_valid) < DEPTH, computed from registers only and independent of out_ready.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opc}.
  - I: {off[11:0], rs1, funct3, rd, opc}.
  - S: {off[11:5], rs2, rs1, funct3, off[4:0], opc}.
  - B: {off[12], off[10:5], rs2, rs1, funct3, off[4:1], off[11], opc}.
  - U: {off[19:0], rd, opc}.
  - J: {off[20], off[10:1], off[11], off[19:12], rd, opc}.
  - SH, opc=0010011: {funct7[6:1], off[5:0], rs1, funct3, rd, opc}.
  - SH, opc=0011011: {funct7, off[4:0], rs1, funct3, rd, opc}.
- Illegal conditions (out_illegal=1, out_insn=32'h00000000):
  - I/S: off[XLEN-1:11] not all equal, i.e. outside [-2048, 2047].
  - B: outside [-4096, 4094], or off[0]=1.
  - J: outside [-2^20, 2^20-2], or off[0]=1.
  - U: off[XLEN-1:20] != 0.
  - SH: off >= 64 for opc 0010011; off >= 32 for opc 0011011; any other opc.
  - fmt=7.
  - in_opc[1:0] != 2'b11.
- Field handling: unused fields (rd for S/B, rs2 for I/U/J) are ignored. funct7 is not validated for R.
- FIFO:
  - Pop on out_valid && out_ready; simultaneous push and pop allowed when full-minus-in-flight permits.
  - Read/write pointers wrap modulo DEPTH.
  - Order is strictly preserved.
  - Outputs are stable while out_valid && !out_ready.

Optional Feature:
- Macro ENC_STATS_EN.
- When defined, adds ports stat_ok (output, 32) and stat_bad (output, 32).
  - Each counts FIFO writes with out_illegal=0 and =1 respectively.
  - Both reset to 0, saturate at 32'hFFFFFFFF, and are not cleared by anything but reset.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- R add x3,x1,x2 (fmt0, opc 0110011, f3 0, f7 0) -> out_insn 0x002081B3, out_illegal 0, out_valid after 2 edges.
- I addi x5,x0,-1 (imm all-ones) -> 0xFFF00293. Same request with imm=2048 -> out_insn 0, out_illegal 1.
- B beq x1,x2, pc=0x1000, target 0x0FFC -> 0xFE208EE3. Target 0x0FFD -> illegal.
- SH slli x1,x1,63 (opc 0010011, f3 1, f7 0) -> 0x03F09093. slliw with shamt 32 (opc 0011011) -> illegal.
- DEPTH=2 with out_ready=0 and in_valid held for 6 cycles -> exactly 2 accepted and in_ready low thereafter. Release out_ready -> words emerge in request order with one pop per cycle.
- Assert reset with 2 FIFO entries and 1 in flight -> out_valid=0 immediately. After release, no stale entry appears and in_ready=1.

Source files
------------

// File: rtl/rv64_encoder_if.sv
// Request/response bundle for rv64_encoder: decoded fields in, packed words out.
// master drives requests and consumes words; slave is the encoder.
interface rv64_encoder_if #(
   parameter int unsigned XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_fmt;
   logic [6:0]      in_opc;
   logic [2:0]      in_funct3;
   logic [6:0]      in_funct7;
   logic [4:0]      in_rd;
   logic [4:0]      in_rs1;
   logic [4:0]      in_rs2;
   logic [XLEN-1:0] in_imm;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_insn;
   logic            out_illegal;
   logic [XLEN-1:0] out_pc;

   modport master (
      output in_valid, in_fmt, in_opc, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
             in_imm, in_pc, out_ready,
      input  in_ready, out_valid, out_insn, out_illegal, out_pc
   );

   modport slave (
      input  in_valid, in_fmt, in_opc, in_funct3, in_funct7, in_rd, in_rs1, in_rs2,
             in_imm, in_pc, out_ready,
      output in_ready, out_valid, out_insn, out_illegal, out_pc
   );
endinterface

// File: rtl/rv64_encoder.sv
// RV64IM instruction encoder: offset stage, range-check/pack stage, output FIFO.
// Optional ENC_STATS_EN adds saturating counters of legal/illegal words written.
module rv64_encoder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned XLEN  = 64
) (
   input logic           clk,
   input logic           reset,
   rv64_encoder_if.slave bus
`ifdef ENC_STATS_EN
   ,
   output logic [31:0]   stat_ok,
   output logic [31:0]   stat_bad
`endif
);
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   localparam logic [2:0] FmtR = 3'd0, FmtI = 3'd1, FmtS = 3'd2, FmtB = 3'd3;
   localparam logic [2:0] FmtU = 3'd4, FmtJ = 3'd5, FmtSh = 3'd6;

   logic            s1_valid_q;
   logic [2:0]      s1_fmt_q;
   logic [6:0]      s1_opc_q;
   logic [2:0]      s1_f3_q;
   logic [6:0]      s1_f7_q;
   logic [4:0]      s1_rd_q, s1_rs1_q, s1_rs2_q;
   logic [XLEN-1:0] s1_off_q, s1_pc_q, off_d;

   logic            s2_valid_q, s2_ill_q, pack_ill;
   logic [31:0]     s2_insn_q, pack_insn;
   logic [XLEN-1:0] s2_pc_q;

   logic [31:0]     insn_mem [DEPTH];
   logic            ill_mem  [DEPTH];
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic [CntW:0]   occupancy;
   logic            accept, push, pop;

   // Occupancy counts words already in the pipeline so the stages never need to stall.
   assign occupancy   = (CntW+1)'(count_q) + (CntW+1)'(s1_valid_q) + (CntW+1)'(s2_valid_q);
   assign bus.in_ready = !reset && (occupancy < (CntW+1)'(DEPTH));
   assign accept      = bus.in_valid && bus.in_ready;
   assign push        = s2_valid_q;
   assign pop         = bus.out_valid && bus.out_ready;

   assign off_d = (bus.in_fmt == FmtB || bus.in_fmt == FmtJ) ? bus.in_imm - bus.in_pc
                                                              : bus.in_imm;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_fmt_q   <= '0;
         s1_opc_q   <= '0;
         s1_f3_q    <= '0;
         s1_f7_q    <= '0;
         s1_rd_q    <= '0;
         s1_rs1_q   <= '0;
         s1_rs2_q   <= '0;
         s1_off_q   <= '0;
         s1_pc_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_fmt_q <= bus.in_fmt;
            s1_opc_q <= bus.in_opc;
            s1_f3_q  <= bus.in_funct3;
            s1_f7_q  <= bus.in_funct7;
            s1_rd_q  <= bus.in_rd;
            s1_rs1_q <= bus.in_rs1;
            s1_rs2_q <= bus.in_rs2;
            s1_off_q <= off_d;
            s1_pc_q  <= bus.in_pc;
         end
      end
   end

   always_comb begin
      pack_insn = '0;
      pack_ill  = 1'b0;
      unique case (s1_fmt_q)
         FmtR: pack_insn = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
         FmtI: begin
            pack_ill  = !((s1_off_q[XLEN-1:11] == '0) || (s1_off_q[XLEN-1:11] == '1));
            pack_insn = {s1_off_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
         end
         FmtS: begin
            pack_ill  = !((s1_off_q[XLEN-1:11] == '0) || (s1_off_q[XLEN-1:11] == '1));
            pack_insn = {s1_off_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_off_q[4:0], s1_opc_q};
         end
         FmtB: begin
            pack_ill  = s1_off_q[0] ||
                        !((s1_off_q[XLEN-1:12] == '0) || (s1_off_q[XLEN-1:12] == '1));
            pack_insn = {s1_off_q[12], s1_off_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                         s1_off_q[4:1], s1_off_q[11], s1_opc_q};
         end
         FmtU: begin
            pack_ill  = (s1_off_q[XLEN-1:20] != '0);
            pack_insn = {s1_off_q[19:0], s1_rd_q, s1_opc_q};
         end
         FmtJ: begin
            pack_ill  = s1_off_q[0] ||
                        !((s1_off_q[XLEN-1:20] == '0) || (s1_off_q[XLEN-1:20] == '1));
            pack_insn = {s1_off_q[20], s1_off_q[10:1], s1_off_q[11], s1_off_q[19:12],
                         s1_rd_q, s1_opc_q};
         end
         FmtSh: begin
            if (s1_opc_q == 7'b0010011) begin
               pack_ill  = (s1_off_q[XLEN-1:6] != '0);
               pack_insn = {s1_f7_q[6:1], s1_off_q[5:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
            end else if (s1_opc_q == 7'b0011011) begin
               pack_ill  = (s1_off_q[XLEN-1:5] != '0);
               pack_insn = {s1_f7_q, s1_off_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_opc_q};
            end else begin
               pack_ill = 1'b1;
            end
         end
         default: pack_ill = 1'b1;
      endcase
      if (s1_opc_q[1:0] != 2'b11) pack_ill = 1'b1;
      if (pack_ill) pack_insn = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         s2_insn_q  <= '0;
         s2_ill_q   <= 1'b0;
         s2_pc_q    <= '0;
      end else begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_insn_q <= pack_insn;
            s2_ill_q  <= pack_ill;
            s2_pc_q   <= s1_pc_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem[wr_ptr_q] <= s2_insn_q;
         ill_mem[wr_ptr_q]  <= s2_ill_q;
         pc_mem[wr_ptr_q]   <= s2_pc_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (!push && pop) count_q <= count_q - 1'b1;
      end
   end

   // Gate the head so an empty FIFO presents zeros rather than stale storage.
   assign bus.out_valid   = (count_q != '0);
   assign bus.out_insn    = bus.out_valid ? insn_mem[rd_ptr_q] : '0;
   assign bus.out_illegal = bus.out_valid ? ill_mem[rd_ptr_q] : 1'b0;
   assign bus.out_pc      = bus.out_valid ? pc_mem[rd_ptr_q] : '0;

`ifdef ENC_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_ok  <= '0;
         stat_bad <= '0;
      end else if (push) begin
         if (s2_ill_q) begin
            if (stat_bad != '1) stat_bad <= stat_bad + 1'b1;
         end else begin
            if (stat_ok != '1) stat_ok <= stat_ok + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rv64_encoder.sv
// Directed bench for rv64_encoder: packing, range limits, latency, backpressure, reset.
// A DEPTH=4 instance carries most vectors; a DEPTH=2 instance covers the full-FIFO case.
module tb_rv64_encoder;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rv64_encoder_if #(.XLEN(64)) bus ();
   rv64_encoder_if #(.XLEN(64)) bus2 ();

`ifdef ENC_STATS_EN
   logic [31:0] stat_ok, stat_bad, stat_ok2, stat_bad2;
`endif

   rv64_encoder #(.DEPTH(4), .XLEN(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus)
`ifdef ENC_STATS_EN
      ,
      .stat_ok  (stat_ok),
      .stat_bad (stat_bad)
`endif
   );

   rv64_encoder #(.DEPTH(2), .XLEN(64)) dut2 (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus2)
`ifdef ENC_STATS_EN
      ,
      .stat_ok  (stat_ok2),
      .stat_bad (stat_bad2)
`endif
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [63:0] imm, input logic [63:0] pc);
      bus.in_fmt    = fmt;
      bus.in_opc    = opc;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_imm    = imm;
      bus.in_pc     = pc;
   endtask

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input string tag);
      int n = 0;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) check_eq({tag, ".send_timeout"}, 64'd0, 64'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [31:0] exp_insn, input logic exp_ill,
                       input logic [63:0] exp_pc);
      int n = 0;
      bus.out_ready = 1'b1;
      while (!bus.out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.out_valid) begin
         check_eq({tag, ".recv_timeout"}, 64'd0, 64'd1);
      end else begin
         check_eq({tag, ".insn"}, 64'(bus.out_insn), 64'(exp_insn));
         check_eq({tag, ".illegal"}, 64'(bus.out_illegal), 64'(exp_ill));
         check_eq({tag, ".pc"}, bus.out_pc, exp_pc);
         @(posedge clk); #1;
      end
   endtask

   task automatic vec(input string tag, input logic [2:0] fmt, input logic [6:0] opc,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [63:0] imm,
                      input logic [63:0] pc, input logic [31:0] exp_insn, input logic exp_ill);
      set_req(fmt, opc, f3, f7, rd, rs1, rs2, imm, pc);
      send(tag);
      recv(tag, exp_insn, exp_ill, pc);
   endtask

   initial begin
      int acc;
      logic rdy;

      reset = 1'b1;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus2.in_valid  = 1'b0;
      bus2.out_ready = 1'b0;
      set_req(3'd0, 7'h33, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
      bus2.in_fmt    = 3'd0;
      bus2.in_opc    = 7'b0110011;
      bus2.in_funct3 = 3'd0;
      bus2.in_funct7 = 7'd0;
      bus2.in_rd     = 5'd0;
      bus2.in_rs1    = 5'd1;
      bus2.in_rs2    = 5'd2;
      bus2.in_imm    = 64'd0;
      bus2.in_pc     = 64'd0;

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst.out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst.in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("rst.out_insn", 64'(bus.out_insn), 64'd0);
      check_eq("rst.out_illegal", 64'(bus.out_illegal), 64'd0);
      check_eq("rst.out_pc", bus.out_pc, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst.in_ready", 64'(bus.in_ready), 64'd1);

      // add x3,x1,x2 with explicit two-edge latency check
      set_req(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 64'h40);
      send("add");
      check_eq("lat.edge_n", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check_eq("lat.edge_n1", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      check_eq("lat.edge_n2", 64'(bus.out_valid), 64'd1);
      recv("add", 32'h002081B3, 1'b0, 64'h40);

      vec("addi_m1", 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, '1, 64'h44,
          32'hFFF00293, 1'b0);
      vec("addi_2048", 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd2048, 64'h48,
          32'h0, 1'b1);
      vec("addi_m2048", 3'd1, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, -64'sd2048, 64'h4C,
          32'h80000293, 1'b0);
      vec("sw", 3'd2, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 64'd8, 64'h50,
          32'h0020A423, 1'b0);
      vec("beq_m4", 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'h0FFC, 64'h1000,
          32'hFE208EE3, 1'b0);
      vec("beq_odd", 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'h0FFD, 64'h1000,
          32'h0, 1'b1);
      vec("beq_m4096", 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'h1000, 64'h2000,
          32'h80208063, 1'b0);
      vec("beq_p4096", 3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'h2000, 64'h1000,
          32'h0, 1'b1);
      vec("lui", 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h12345, 64'h60,
          32'h123450B7, 1'b0);
      vec("lui_big", 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h100000, 64'h64,
          32'h0, 1'b1);
      vec("jal", 3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'h108, 64'h100,
          32'h008000EF, 1'b0);
      vec("slli63", 3'd6, 7'b0010011, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 64'd63, 64'h70,
          32'h03F09093, 1'b0);
      vec("srai5", 3'd6, 7'b0010011, 3'd5, 7'h20, 5'd1, 5'd1, 5'd0, 64'd5, 64'h74,
          32'h4050D093, 1'b0);
      vec("slliw31", 3'd6, 7'b0011011, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 64'd31, 64'h78,
          32'h01F0909B, 1'b0);
      vec("slliw32", 3'd6, 7'b0011011, 3'd1, 7'd0, 5'd1, 5'd1, 5'd0, 64'd32, 64'h7C,
          32'h0, 1'b1);
      vec("fmt7", 3'd7, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 64'h80,
          32'h0, 1'b1);
      vec("opc_lo", 3'd0, 7'b0110010, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd0, 64'h84,
          32'h0, 1'b1);

      // DEPTH=2 instance: hold in_valid with the consumer stalled
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         bus2.in_rd    = 5'(acc + 1);
         bus2.in_valid = 1'b1;
         rdy = bus2.in_ready;
         @(posedge clk); #1;
         if (rdy) acc++;
      end
      bus2.in_valid = 1'b0;
      check_eq("bp.accepted", 64'(acc), 64'd2);
      check_eq("bp.in_ready_low", 64'(bus2.in_ready), 64'd0);
      bus2.out_ready = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         check_eq("bp.out_valid", 64'(bus2.out_valid), 64'd1);
         check_eq("bp.order", 64'(bus2.out_insn), 64'(32'h00208033 | (32'(k) << 7)));
         @(posedge clk); #1;
      end
      check_eq("bp.drained", 64'(bus2.out_valid), 64'd0);
      check_eq("bp.in_ready_back", 64'(bus2.in_ready), 64'd1);

      // Reset with two words queued and one in flight
      bus.out_ready = 1'b0;
      set_req(3'd0, 7'b0110011, 3'd0, 7'd0, 5'd7, 5'd1, 5'd2, 64'd0, 64'h90);
      send("rs_a");
      send("rs_b");
      send("rs_c");
      @(posedge clk); #1;
      check_eq("rs.pre_valid", 64'(bus.out_valid), 64'd1);
      reset = 1'b1;
      #1;
      check_eq("rs.out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rs.in_ready", 64'(bus.in_ready), 64'd0);
      check_eq("rs.out_insn", 64'(bus.out_insn), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check_eq("rs.no_stale", 64'(bus.out_valid), 64'd0);
      end
      check_eq("rs.in_ready_after", 64'(bus.in_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
